switch_bank_debounced: RTL and testbench



---
 rtl/switch_pkg.sv | 24 ++
 rtl/switch_debounce.sv | 89 ++++++++
 rtl/switch_bank_debounced.sv | 153 +++++++++++++++
 tb/tb_switch_bank_debounced.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
// Shared constants for the debounced DIP-switch bank peripheral: the word
// address map, register bit positions and the change-counter helper.
// ---------------------------------------------------------------------------
package switch_pkg;

    // Word address map
    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_DATA0  = 2;

    // Register bit positions
    localparam int IE_BIT      = 0;   // CTRL
    localparam int PEND_BIT    = 0;   // STATUS
    localparam int CHG_CNT_LSB = 8;   // STATUS[15:8]
    localparam int CHG_CNT_MAX = 255;

    // Saturating increment of the 8-bit change counter.
    function automatic logic [7:0] chg_cnt_inc(input logic [7:0] v);
        return (v == 8'(CHG_CNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// Converts active-low switch pins to active-high, passes them through a 2-FF
// synchroniser and commits the whole bank once it has been stable for
// DEB_CYCLES consecutive cycles.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   dip_n    in   raw switch pins, active-low
//   state    out  debounced switch state (1 = switch on)
//   changed  out  bits where the pending candidate differs from state
//   commit   out  single-cycle pulse; state takes the candidate on this edge
// ---------------------------------------------------------------------------
module switch_debounce #(
    parameter int WIDTH      = 64,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dip_n,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] changed,
    output logic             commit
);

    localparam int                CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q,  cand_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic stable;
    logic at_max;

    // Commit is combinational so the register file sees it on the same edge
    // that state is loaded; no extra latency is added to PEND.
    assign stable  = (sync2_q == cand_q);
    assign at_max  = (cnt_q == CNT_MAX);
    assign changed = cand_q ^ state_q;
    assign commit  = stable && at_max && (|changed);
    assign state   = state_q;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sync1_d = ~dip_n;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!stable) begin
            // Any movement restarts the stability window.
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (at_max) begin
            // Counter holds at its maximum until the inputs move again.
            if (commit) begin
                state_d = cand_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous, checked inside the
    // clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/switch_bank_debounced.sv
// ---------------------------------------------------------------------------
// switch_bank_debounced
// Bus peripheral exposing N_BYTES groups of active-low DIP switches through a
// debouncer and a small register file (CTRL, STATUS, DATA words) with a
// level interrupt. Reads are combinational on addr; writes happen on the
// rising clock edge while we=1.
//
// Optional build macro SWITCH_MASK_EN adds per-bit MASK words after the DATA
// words; only changes on unmasked bits raise PEND / CHG_CNT.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   dip   in   raw switch pins, active-low, byte k = dip[8k+7:8k]
//   addr  in   word address
//   we    in   write strobe
//   din   in   write data
//   dout  out  read data (combinational)
//   irq   out  interrupt request = PEND & IE
// ---------------------------------------------------------------------------
module switch_bank_debounced
    import switch_pkg::*;
#(
    parameter int N_BYTES    = 8,
    parameter int DEB_CYCLES = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_BYTES-1:0] dip,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 we,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 irq
);

    localparam int WIDTH   = 8 * N_BYTES;
    localparam int N_WORDS = N_BYTES / 4;

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] changed;
    logic             commit;
    logic             raise;

    logic       ie_q,      ie_d;
    logic       pend_q,    pend_d;
    logic [7:0] chg_cnt_q, chg_cnt_d;

    switch_debounce #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .dip_n   (dip),
        .state   (state),
        .changed (changed),
        .commit  (commit)
    );

`ifdef SWITCH_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    // State always follows the switches; the mask only gates notification.
    assign raise = commit && (|(changed & mask_q));

    always_comb begin
        mask_d = mask_q;
        if (we) begin
            for (int j = 0; j < N_WORDS; j++) begin
                if (addr == ADDR_W'(ADDR_DATA0 + N_WORDS + j)) begin
                    mask_d[32*j +: 32] = din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    logic unused_bits;

    assign raise       = commit;
    assign unused_bits = ^{din[31:1], changed};
`endif

    // Register-file update. The commit is applied after the bus write so a
    // simultaneous STATUS clear loses to the new event.
    always_comb begin
        ie_d      = ie_q;
        pend_d    = pend_q;
        chg_cnt_d = chg_cnt_q;

        if (we) begin
            if (addr == ADDR_W'(ADDR_CTRL)) begin
                ie_d = din[IE_BIT];
            end
            if (addr == ADDR_W'(ADDR_STATUS) && din[PEND_BIT]) begin
                pend_d    = 1'b0;
                chg_cnt_d = '0;
            end
        end

        if (raise) begin
            pend_d    = 1'b1;
            chg_cnt_d = chg_cnt_inc(chg_cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            chg_cnt_q <= '0;
        end else begin
            ie_q      <= ie_d;
            pend_q    <= pend_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    // Purely a function of flops, so it cannot glitch on bus activity.
    assign irq = pend_q & ie_q;

    // Read mux; anything not decoded returns zero.
    always_comb begin
        dout = '0;
        if (addr == ADDR_W'(ADDR_CTRL)) begin
            dout[IE_BIT] = ie_q;
        end
        if (addr == ADDR_W'(ADDR_STATUS)) begin
            dout[PEND_BIT]             = pend_q;
            dout[CHG_CNT_LSB +: 8]     = chg_cnt_q;
        end
        for (int j = 0; j < N_WORDS; j++) begin
            if (addr == ADDR_W'(ADDR_DATA0 + j)) begin
                dout = state[32*j +: 32];
            end
`ifdef SWITCH_MASK_EN
            if (addr == ADDR_W'(ADDR_DATA0 + N_WORDS + j)) begin
                dout = mask_q[32*j +: 32];
            end
`endif
        end
    end

endmodule

// File: tb/tb_switch_bank_debounced.sv
// ---------------------------------------------------------------------------
// tb_switch_bank_debounced
// Directed bench for switch_bank_debounced with N_BYTES=8, DEB_CYCLES=4.
// Inputs change 1 ns after a rising edge; a pin change made after edge 0
// is expected in state after edge 7 (DEB_CYCLES+3).
// ---------------------------------------------------------------------------
module tb_switch_bank_debounced;

    localparam int N_BYTES = 8;
    localparam int DEB     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] dip;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_bank_debounced #(
        .N_BYTES    (N_BYTES),
        .DEB_CYCLES (DEB),
        .ADDR_W     (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dip  (dip),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    initial begin
        logic [7:0] pv;

        rst  = 1'b1;
        dip  = '1;
        addr = 4'd0;
        we   = 1'b0;
        din  = '0;

        // ---------------- reset state ----------------
        tick(3);
        chk_rd("rst_data0", 4'd2, 32'h0);
        chk_rd("rst_data1", 4'd3, 32'h0);
        chk_rd("rst_status", 4'd1, 32'h0);
        chk_rd("rst_ctrl", 4'd0, 32'h0);
        chk_irq("rst_irq", 1'b0);
`ifdef SWITCH_MASK_EN
        chk_rd("rst_mask0", 4'd4, 32'hFFFF_FFFF);
`else
        chk_rd("nomask_w4", 4'd4, 32'h0);
        chk_rd("nomask_w5", 4'd5, 32'h0);
`endif
        rst = 1'b0;

        // ---------------- latency of a single change ----------------
        tick(1);                       // edge 0
        dip[7:0] = 8'hFE;
        tick(6);                       // edge 6
        chk_rd("lat_edge6", 4'd2, 32'h0);
        tick(1);                       // edge 7
        chk_rd("lat_edge7", 4'd2, 32'h0000_0001);
        chk_rd("lat_status", 4'd1, 32'h0000_0101);
        chk_irq("lat_irq_masked", 1'b0);

        wr(4'd1, 32'h1);
        chk_rd("clr_status", 4'd1, 32'h0);

        // Back to off; that is a change too.
        dip[0] = 1'b1;
        tick(8);
        chk_rd("off_data0", 4'd2, 32'h0);
        chk_rd("off_status", 4'd1, 32'h0000_0101);
        wr(4'd1, 32'h1);

        // ---------------- bouncing input ----------------
        for (int k = 0; k < 10; k++) begin
            dip[0] = ~dip[0];
            tick(2);
        end
        chk_rd("bounce_nocommit", 4'd1, 32'h0);
        dip[0] = 1'b0;                 // settle on; last change, edge 0
        tick(6);
        chk_rd("bounce_edge6_data", 4'd2, 32'h0);
        chk_rd("bounce_edge6_stat", 4'd1, 32'h0);
        tick(1);
        chk_rd("bounce_edge7_data", 4'd2, 32'h0000_0001);
        chk_rd("bounce_edge7_stat", 4'd1, 32'h0000_0101);
        tick(10);
        chk_rd("bounce_once", 4'd1, 32'h0000_0101);

        // ---------------- interrupt enable ----------------
        wr(4'd0, 32'h1);
        chk_irq("ie_set_pend", 1'b1);
        chk_rd("ctrl_ie", 4'd0, 32'h1);

        // STATUS clear on the same edge as a new commit: set wins.
        dip[1] = 1'b0;                 // edge 0
        tick(6);
        addr = 4'd1;
        din  = 32'h1;
        we   = 1'b1;
        tick(1);                       // edge 7: commit + clear
        we   = 1'b0;
        chk_rd("clr_vs_commit", 4'd1, 32'h0000_0101);
        chk_rd("clr_vs_data", 4'd2, 32'h0000_0003);
        chk_irq("clr_vs_irq", 1'b1);

        wr(4'd1, 32'h1);
        chk_rd("clr_status2", 4'd1, 32'h0);
        chk_irq("clr_irq", 1'b0);

        // IE masks irq without touching PEND; re-enable asserts at once.
        dip[2] = 1'b0;
        tick(8);
        chk_irq("irq_on_commit", 1'b1);
        wr(4'd0, 32'h0);
        chk_irq("ie_off_irq", 1'b0);
        chk_rd("ie_off_pend", 4'd1, 32'h0000_0101);
        wr(4'd0, 32'h1);
        chk_irq("ie_on_irq", 1'b1);
        wr(4'd1, 32'h1);
        chk_irq("ie_on_clr", 1'b0);

        // ---------------- unmapped accesses ----------------
        chk_rd("unmapped_rd", 4'hF, 32'h0);
        wr(4'hF, 32'hFFFF_FFFF);
        chk_rd("unmapped_wr_ctrl", 4'd0, 32'h1);
        chk_rd("unmapped_wr_stat", 4'd1, 32'h0);

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 300; i++) begin
            pv = 8'(i);
            dip[63:56] = pv;
            tick(8);
            if (i == 0 || i == 150 || i == 299) begin
                chk_rd("sat_data1", 4'd3, {~pv, 24'h0});
            end
            if (i == 253) begin
                chk_rd("sat_254", 4'd1, 32'h0000_FE01);
            end
            if (i == 254) begin
                chk_rd("sat_255", 4'd1, 32'h0000_FF01);
            end
        end
        chk_rd("sat_300", 4'd1, 32'h0000_FF01);
        wr(4'd1, 32'h0);
        chk_rd("status_wr0", 4'd1, 32'h0000_FF01);
        chk_rd("sat_final_data1", 4'd3, 32'hD400_0000);

`ifdef SWITCH_MASK_EN
        // ---------------- change mask ----------------
        wr(4'd1, 32'h1);
        wr(4'd4, 32'h0);
        chk_rd("mask0_zero", 4'd4, 32'h0);
        dip[0] = 1'b1;
        tick(8);
        chk_rd("masked_data0", 4'd2, 32'h0000_0006);
        chk_rd("masked_status", 4'd1, 32'h0);
        wr(4'd4, 32'h1);
        chk_rd("mask0_one", 4'd4, 32'h1);
        chk_rd("mask1_reset", 4'd5, 32'hFFFF_FFFF);
        dip[0] = 1'b0;
        tick(8);
        chk_rd("unmasked_status", 4'd1, 32'h0000_0101);
        chk_rd("unmasked_data0", 4'd2, 32'h0000_0007);
`endif

        // ---------------- reset mid-debounce ----------------
        dip[3] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);                       // edge R samples reset
        rst = 1'b0;
        chk_rd("rst2_data0", 4'd2, 32'h0);
        chk_rd("rst2_status", 4'd1, 32'h0);
        chk_rd("rst2_ctrl", 4'd0, 32'h0);
        tick(6);
        chk_rd("rst2_edge6", 4'd2, 32'h0);
        tick(1);
        chk_rd("rst2_edge7", 4'd2, 32'h0000_000F);
        chk_rd("rst2_data1", 4'd3, 32'hD400_0000);
        chk_rd("rst2_status7", 4'd1, 32'h0000_0101);
        chk_irq("rst2_irq", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
